// File: rtl/csr_unit_if.sv
// csr_unit_if: CSR access port between the execute stage (master) and csr_unit (slave).
interface csr_unit_if;
   logic        csr_en;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   modport master (output csr_en, csr_op, csr_addr, csr_wdata, input csr_rdata, csr_illegal);
   modport slave (input csr_en, csr_op, csr_addr, csr_wdata, output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_unit.sv
// csr_unit: RV32 machine-mode CSR file with HPM counters, mcountinhibit and prioritised interrupts.
// Define CSR_VECTORED_EN to make mtvec MODE writable and vector interrupts to base + 4*cause.
module csr_unit #(
   parameter int          NUM_HPM    = 4,
   parameter int          NUM_EVENTS = 8,
   parameter int          CNT_W      = 64,
   parameter logic [31:0] HART_ID    = 32'h0,
   parameter logic [31:0] MTVEC_RST  = 32'h8000_0100
) (
   input  logic                  clk,
   input  logic                  rst,
   csr_unit_if.slave             bus,
   input  logic                  exc_valid,
   input  logic [31:0]           exc_pc,
   input  logic [4:0]            exc_cause,
   input  logic [31:0]           exc_tval,
   input  logic                  irq_take,
   input  logic [31:0]           irq_pc,
   input  logic                  mret,
   input  logic                  retire,
   input  logic [NUM_EVENTS-1:0] hpm_event,
   input  logic                  msip,
   input  logic                  mtip,
   input  logic                  meip,
   output logic                  irq_pending,
   output logic [4:0]            irq_cause,
   output logic [31:0]           trap_target,
   output logic [31:0]           mepc_o
);
   localparam int NH  = NUM_HPM > 0 ? NUM_HPM : 1;
   localparam int NC  = 3 + NH;
   localparam int EW  = NUM_EVENTS > 1 ? $clog2(NUM_EVENTS) : 1;
   localparam int EVW = 1 << EW;
   localparam logic [31:0] INH_MASK = 32'h5 | (32'((64'd1 << NUM_HPM) - 64'd1) << 3);
   function automatic logic [31:0] mtvec_fix(input logic [31:0] v);
`ifdef CSR_VECTORED_EN
      return {v[31:2], 1'b0, v[1:0] == 2'b01};
`else
      return v & 32'hFFFF_FFFC;
`endif
   endfunction
   localparam logic [31:0] MTVEC_INIT = mtvec_fix(MTVEC_RST);
   logic             mst_mie_q, mst_mie_d, mpie_q, mpie_d;
   logic [2:0]       mie_q, mie_d, mip_q, mip_d;
   logic [31:0]      mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
   logic [31:0]      mtval_q, mtval_d, mscratch_q, mscratch_d, inh_q, inh_d;
   logic [CNT_W-1:0] cnt_q [NC];
   logic [CNT_W-1:0] cnt_d [NC];
   logic [EW-1:0]    evt_q [NH];
   logic [EW-1:0]    evt_d [NH];
   logic [11:0]      a;
   logic [1:0]       op;
   logic [31:0]      mstatus, mie_v, mip_v, old, wv, base;
   logic [2:0]       en_irq;
   logic [EVW-1:0]   ev_ext;
   logic             known, illegal, cnt_sel, evt_sel, take, we;
   assign a       = bus.csr_addr;
   assign op      = bus.csr_op;
   assign mstatus = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mst_mie_q, 3'b0};
   assign mie_v   = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
   assign mip_v   = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};
   assign cnt_sel = (a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00;
   assign evt_sel = a[11:5] == 7'b0011_001;
   assign ev_ext  = EVW'(hpm_event);
   always_comb begin
      old = '0;
      known = 1'b1;
      case (a)
         12'h300: old = mstatus;
         12'h304: old = mie_v;
         12'h305: old = mtvec_q;
         12'h320: old = inh_q;
         12'h340: old = mscratch_q;
         12'h341: old = mepc_q;
         12'h342: old = mcause_q;
         12'h343: old = mtval_q;
         12'h344: old = mip_v;
         12'hF11, 12'hF12, 12'hF13: old = '0;
         12'hF14: old = HART_ID;
         default: known = 1'b0;
      endcase
      for (int k = 0; k < NC; k++)
         if (cnt_sel && k != 1 && k < 3 + NUM_HPM && a[4:0] == 5'(k)) begin
            known = 1'b1;
            old = a[7] ? 32'(cnt_q[k][CNT_W-1:32]) : cnt_q[k][31:0];
         end
      for (int i = 0; i < NUM_HPM; i++)
         if (evt_sel && a[4:0] == 5'(i + 3)) begin
            known = 1'b1;
            old = 32'(evt_q[i]);
         end
   end
   assign illegal         = !known || (a[11:10] == 2'b11 && op != 2'b00);
   assign bus.csr_illegal = illegal;
   assign bus.csr_rdata   = illegal ? '0 : old;
   assign wv = op == 2'b01 ? bus.csr_wdata : op == 2'b10 ? old | bus.csr_wdata : old & ~bus.csr_wdata;
   assign en_irq      = mie_q & mip_q;
   assign irq_pending = mst_mie_q && |en_irq;
   assign irq_cause   = !irq_pending ? 5'd0 : en_irq[2] ? 5'd11 : en_irq[0] ? 5'd3 : 5'd7;
   assign take        = irq_take && irq_pending;
   assign we          = bus.csr_en && op != 2'b00 && !illegal && !exc_valid && !take && !mret;
   assign mepc_o      = mepc_q;
   assign base        = {mtvec_q[31:2], 2'b00};
`ifdef CSR_VECTORED_EN
   assign trap_target = !exc_valid && mtvec_q[0] ? base + {25'b0, irq_cause, 2'b00} : base;
`else
   assign trap_target = base;
`endif
   always_comb begin
      mst_mie_d  = mst_mie_q;
      mpie_d     = mpie_q;
      mie_d      = mie_q;
      mip_d      = {meip, mtip, msip};
      mtvec_d    = mtvec_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      mscratch_d = mscratch_q;
      inh_d      = inh_q;
      evt_d      = evt_q;
      for (int k = 0; k < NC; k++) cnt_d[k] = cnt_q[k];
      cnt_d[0] = cnt_q[0] + CNT_W'(!inh_q[0]);
      cnt_d[2] = cnt_q[2] + CNT_W'(retire && !inh_q[2]);
      for (int i = 0; i < NUM_HPM; i++)
         cnt_d[i+3] = cnt_q[i+3] + CNT_W'(ev_ext[evt_q[i]] && !inh_q[i+3]);
      if (exc_valid || take) begin
         mepc_d    = (exc_valid ? exc_pc : irq_pc) & 32'hFFFF_FFFC;
         mcause_d  = exc_valid ? {27'b0, exc_cause} : {1'b1, 26'b0, irq_cause};
         mtval_d   = exc_valid ? exc_tval : '0;
         mpie_d    = mst_mie_q;
         mst_mie_d = 1'b0;
      end else if (mret) begin
         mst_mie_d = mpie_q;
         mpie_d    = 1'b1;
      end else if (we) begin
         case (a)
            12'h300: begin
               mst_mie_d = wv[3];
               mpie_d    = wv[7];
            end
            12'h304: mie_d = {wv[11], wv[7], wv[3]};
            12'h305: mtvec_d = mtvec_fix(wv);
            12'h320: inh_d = wv & INH_MASK;
            12'h340: mscratch_d = wv;
            12'h341: mepc_d = wv & 32'hFFFF_FFFC;
            12'h342: mcause_d = wv;
            12'h343: mtval_d = wv;
            default: ;
         endcase
         // A write to one half overrides that cycle's increment and holds the other half.
         for (int k = 0; k < NC; k++)
            if (cnt_sel && a[4:0] == 5'(k))
               cnt_d[k] = a[7] ? {wv[CNT_W-33:0], cnt_q[k][31:0]} : {cnt_q[k][CNT_W-1:32], wv};
         for (int i = 0; i < NUM_HPM; i++)
            if (evt_sel && a[4:0] == 5'(i + 3)) evt_d[i] = wv[EW-1:0];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mst_mie_q  <= 1'b0;
         mpie_q     <= 1'b0;
         mie_q      <= '0;
         mip_q      <= '0;
         mtvec_q    <= MTVEC_INIT;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mscratch_q <= '0;
         inh_q      <= '0;
         for (int k = 0; k < NC; k++) cnt_q[k] <= '0;
         for (int i = 0; i < NH; i++) evt_q[i] <= '0;
      end else begin
         mst_mie_q  <= mst_mie_d;
         mpie_q     <= mpie_d;
         mie_q      <= mie_d;
         mip_q      <= mip_d;
         mtvec_q    <= mtvec_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
         mscratch_q <= mscratch_d;
         inh_q      <= inh_d;
         cnt_q      <= cnt_d;
         evt_q      <= evt_d;
      end
   end
endmodule
